bus_interface_unit: RTL and testbench

//  Parametrised CPU memory-access unit: turns single requests from the control path (opcode fetch,

---
 rtl/bus_interface_unit.sv | 128 ++++++++++++
 tb/tb_bus_interface_unit.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_interface_unit.sv
// Memory-access unit: turns single control-path requests into one- or two-beat
// memory bus cycles with wait states, external stalls and a one-cycle response pulse.
module bus_interface_unit #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [1:0]          req_op,
  input  logic                req_wide,
  input  logic                req_desc,
  input  logic                req_hipage,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic                resp_valid,
  output logic                resp_fetch,
  output logic [2*DATA_W-1:0] resp_rdata,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_re,
  output logic                mem_we,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ready
);
  localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CNT_W-1:0] WS_INIT = CNT_W'(WAIT_STATES);
  localparam logic [ADDR_W-9:0] PAGE_ONES = '1;
  localparam logic [1:0] OP_FETCH = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

  state_t              state, state_nxt;
  logic [1:0]          op_q;
  logic                wide_q, desc_q, hipage_q;
  logic [2*DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0]   first_q;
  logic [CNT_W-1:0]    cnt_q;

  logic                accept, in_beat, beat_done, wide_eff;
  logic [ADDR_W-1:0]   req_addr_eff, addr_step, addr_next;

  assign req_ready    = (state == IDLE);
  assign accept       = req_ready && req_valid && (req_op != OP_RSVD);
  assign wide_eff     = req_wide && (req_op != OP_FETCH);
  assign in_beat      = (state == BEAT0) || (state == BEAT1);
  assign beat_done    = in_beat && (cnt_q == '0) && mem_ready;
  assign req_addr_eff = req_hipage ? {PAGE_ONES, req_addr[7:0]} : req_addr;
  assign addr_step    = desc_q ? (mem_addr - ADDR_W'(1)) : (mem_addr + ADDR_W'(1));
  // In the high page only the low byte walks, so FFFF+1 wraps to FF00.
  assign addr_next    = hipage_q ? {PAGE_ONES, addr_step[7:0]} : addr_step;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = BEAT0;
      BEAT0:   if (beat_done) state_nxt = wide_q ? BEAT1 : RESP;
      BEAT1:   if (beat_done) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q       <= OP_FETCH;
      wide_q     <= 1'b0;
      desc_q     <= 1'b0;
      hipage_q   <= 1'b0;
      wdata_q    <= '0;
      first_q    <= '0;
      cnt_q      <= '0;
      resp_valid <= 1'b0;
      resp_fetch <= 1'b0;
      resp_rdata <= '0;
      mem_addr   <= '0;
      mem_re     <= 1'b0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
    end else begin
      resp_valid <= 1'b0;
      resp_fetch <= 1'b0;
      if (accept) begin
        op_q      <= req_op;
        wide_q    <= wide_eff;
        desc_q    <= req_desc;
        hipage_q  <= req_hipage;
        wdata_q   <= req_wdata;
        mem_addr  <= req_addr_eff;
        mem_re    <= (req_op != OP_WRITE);
        mem_we    <= (req_op == OP_WRITE);
        mem_wdata <= (wide_eff && req_desc) ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
        cnt_q     <= WS_INIT;
      end else if (in_beat) begin
        if (cnt_q != '0) begin
          cnt_q <= cnt_q - CNT_W'(1);
        end else if (mem_ready) begin
          if ((state == BEAT0) && wide_q) begin
            // Strobes stay up straight into the second beat.
            first_q   <= mem_rdata;
            mem_addr  <= addr_next;
            mem_wdata <= desc_q ? wdata_q[DATA_W-1:0] : wdata_q[2*DATA_W-1:DATA_W];
            cnt_q     <= WS_INIT;
          end else begin
            mem_re     <= 1'b0;
            mem_we     <= 1'b0;
            resp_valid <= 1'b1;
            resp_fetch <= (op_q == OP_FETCH);
            if (op_q != OP_WRITE) begin
              if (!wide_q)     resp_rdata <= {{DATA_W{1'b0}}, mem_rdata};
              else if (desc_q) resp_rdata <= {first_q, mem_rdata};
              else             resp_rdata <= {mem_rdata, first_q};
            end
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_bus_interface_unit.sv
// Self-checking bench for bus_interface_unit: directed vector table, WAIT_STATES=2
// corner sequences, mid-transfer reset and randomized transfers against a memory model.
module tb_bus_interface_unit;
  localparam logic [1:0] OP_FETCH = 2'd0, OP_READ = 2'd1, OP_WRITE = 2'd2, OP_RSVD = 2'd3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid, req_ready, req_wide, req_desc, req_hipage;
  logic [1:0]  req_op;
  logic [15:0] req_addr, req_wdata, resp_rdata, mem_addr;
  logic        resp_valid, resp_fetch, mem_re, mem_we, mem_ready;
  logic [7:0]  mem_wdata, mem_rdata;
  logic [7:0]  mem_arr [0:65535];
  assign mem_rdata = mem_arr[mem_addr];

  logic        w2_req_valid, w2_req_ready, w2_req_wide, w2_req_desc, w2_req_hipage;
  logic [1:0]  w2_req_op;
  logic [15:0] w2_req_addr, w2_req_wdata, w2_resp_rdata, w2_mem_addr;
  logic        w2_resp_valid, w2_resp_fetch, w2_mem_re, w2_mem_we, w2_mem_ready;
  logic [7:0]  w2_mem_wdata, w2_mem_rdata;

  bus_interface_unit #(.ADDR_W(16), .DATA_W(8), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_wide(req_wide), .req_desc(req_desc), .req_hipage(req_hipage), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_fetch(resp_fetch),
    .resp_rdata(resp_rdata), .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready));

  bus_interface_unit #(.ADDR_W(16), .DATA_W(8), .WAIT_STATES(2)) dut2 (
    .clk(clk), .rst(rst), .req_valid(w2_req_valid), .req_ready(w2_req_ready), .req_op(w2_req_op),
    .req_wide(w2_req_wide), .req_desc(w2_req_desc), .req_hipage(w2_req_hipage),
    .req_addr(w2_req_addr), .req_wdata(w2_req_wdata), .resp_valid(w2_resp_valid),
    .resp_fetch(w2_resp_fetch), .resp_rdata(w2_resp_rdata), .mem_addr(w2_mem_addr),
    .mem_re(w2_mem_re), .mem_we(w2_mem_we), .mem_wdata(w2_mem_wdata),
    .mem_rdata(w2_mem_rdata), .mem_ready(w2_mem_ready));

  typedef struct packed {
    logic [1:0]  op;
    logic        wide, desc, hip;
    logic [15:0] addr, wdata;
    logic [1:0]  nb;
    logic [15:0] a0, a1;
    logic [7:0]  wd0, wd1;
    logic [15:0] rdata;
    logic        fetch;
  } vec_t;

  int checks = 0;
  int failures = 0;

  int          got_nb, got_lat, got_stalls;
  logic [15:0] got_addr [2];
  logic [7:0]  got_wd [2];
  logic [1:0]  got_strb [2];
  logic [15:0] got_rdata;
  logic        got_fetch, got_ready_resp, got_timeout;

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Issues one request on the WAIT_STATES=0 unit and records every completed beat.
  task automatic apply_stimulus(input logic [1:0] op, input logic wide, desc, hip,
                                input logic [15:0] addr, wdata, input bit stall);
    got_nb = 0; got_stalls = 0; got_lat = 0; got_timeout = 1'b1;
    got_rdata = '0; got_fetch = 1'b0; got_ready_resp = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = op; req_wide = wide; req_desc = desc;
    req_hipage = hip; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    mem_ready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if ((mem_re || mem_we) && mem_ready) begin
        if (got_nb < 2) begin
          got_addr[got_nb] = mem_addr;
          got_wd[got_nb]   = mem_wdata;
          got_strb[got_nb] = {mem_re, mem_we};
        end
        if (mem_we) mem_arr[mem_addr] = mem_wdata;
        got_nb++;
      end else if (mem_re || mem_we) begin
        got_stalls++;
      end
      if (resp_valid) begin
        got_lat = k; got_rdata = resp_rdata; got_fetch = resp_fetch;
        got_ready_resp = req_ready; got_timeout = 1'b0;
        break;
      end
      @(posedge clk); #1;
      mem_ready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    mem_ready = 1'b1;
  endtask

  task automatic check_txn(input int id, input logic [1:0] op, input int nb,
                           input logic [15:0] a0, a1, input logic [7:0] wd0, wd1,
                           input logic [15:0] rdata, input logic fetch);
    logic [1:0] strb;
    strb = (op == OP_WRITE) ? 2'b01 : 2'b10;
    check_output($sformatf("t%0d timeout", id), 32'(got_timeout), 32'd0);
    check_output($sformatf("t%0d beats", id), 32'(got_nb), 32'(nb));
    check_output($sformatf("t%0d latency", id), 32'(got_lat), 32'(nb + got_stalls + 1));
    check_output($sformatf("t%0d addr0", id), 32'(got_addr[0]), 32'(a0));
    check_output($sformatf("t%0d strobe0", id), 32'(got_strb[0]), 32'(strb));
    if (op == OP_WRITE) check_output($sformatf("t%0d wdata0", id), 32'(got_wd[0]), 32'(wd0));
    if (nb == 2 && got_nb >= 2) begin
      check_output($sformatf("t%0d addr1", id), 32'(got_addr[1]), 32'(a1));
      check_output($sformatf("t%0d strobe1", id), 32'(got_strb[1]), 32'(strb));
      if (op == OP_WRITE) check_output($sformatf("t%0d wdata1", id), 32'(got_wd[1]), 32'(wd1));
    end
    check_output($sformatf("t%0d rdata", id), 32'(got_rdata), 32'(rdata));
    check_output($sformatf("t%0d fetch", id), 32'(got_fetch), 32'(fetch));
    check_output($sformatf("t%0d ready_in_resp", id), 32'(got_ready_resp), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t        tbl [10];
    logic [15:0] last_rdata, eff, a1raw, a1, exp_rd, addr, wdata;
    logic [1:0]  op;
    logic        wide, desc, hip, seen;
    logic [7:0]  b0, b1, wd0, wd1;
    int          nb, cnt, lat, stable;

    req_valid = 0; req_op = OP_READ; req_wide = 0; req_desc = 0; req_hipage = 0;
    req_addr = '0; req_wdata = '0; mem_ready = 1'b1;
    w2_req_valid = 0; w2_req_op = OP_READ; w2_req_wide = 0; w2_req_desc = 0; w2_req_hipage = 0;
    w2_req_addr = '0; w2_req_wdata = '0; w2_mem_ready = 1'b1; w2_mem_rdata = 8'hA5;
    for (int i = 0; i < 65536; i++) mem_arr[i] = 8'($urandom);
    mem_arr[16'hC000] = 8'h5A; mem_arr[16'hDFFE] = 8'h12; mem_arr[16'hDFFD] = 8'h34;
    mem_arr[16'hFF00] = 8'h77; mem_arr[16'h1234] = 8'h9C;

    //             op       wide  desc  hip   addr      wdata     nb    a0        a1        wd0    wd1    rdata     fetch
    tbl[0] = '{OP_READ,  1'b0, 1'b0, 1'b0, 16'hC000, 16'h0000, 2'd1, 16'hC000, 16'h0000, 8'h00, 8'h00, 16'h005A, 1'b0};
    tbl[1] = '{OP_WRITE, 1'b1, 1'b0, 1'b0, 16'hFFFF, 16'hBEEF, 2'd2, 16'hFFFF, 16'h0000, 8'hEF, 8'hBE, 16'h005A, 1'b0};
    tbl[2] = '{OP_READ,  1'b1, 1'b1, 1'b0, 16'hDFFE, 16'h0000, 2'd2, 16'hDFFE, 16'hDFFD, 8'h00, 8'h00, 16'h1234, 1'b0};
    tbl[3] = '{OP_READ,  1'b1, 1'b0, 1'b1, 16'h12FF, 16'h0000, 2'd2, 16'hFFFF, 16'hFF00, 8'h00, 8'h00, 16'h77EF, 1'b0};
    tbl[4] = '{OP_READ,  1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 2'd2, 16'h0000, 16'hFFFF, 8'h00, 8'h00, 16'hBEEF, 1'b0};
    tbl[5] = '{OP_FETCH, 1'b1, 1'b1, 1'b0, 16'h1234, 16'h0000, 2'd1, 16'h1234, 16'h0000, 8'h00, 8'h00, 16'h009C, 1'b1};
    tbl[6] = '{OP_WRITE, 1'b0, 1'b0, 1'b1, 16'h5680, 16'h33AA, 2'd1, 16'hFF80, 16'h0000, 8'hAA, 8'h00, 16'h009C, 1'b0};
    tbl[7] = '{OP_READ,  1'b0, 1'b0, 1'b1, 16'h0080, 16'h0000, 2'd1, 16'hFF80, 16'h0000, 8'h00, 8'h00, 16'h00AA, 1'b0};
    tbl[8] = '{OP_WRITE, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h5566, 2'd2, 16'hFF00, 16'hFFFF, 8'h55, 8'h66, 16'h00AA, 1'b0};
    tbl[9] = '{OP_READ,  1'b1, 1'b0, 1'b1, 16'h00FF, 16'h0000, 2'd2, 16'hFFFF, 16'hFF00, 8'h00, 8'h00, 16'h5566, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("reset req_ready", 32'(req_ready), 32'd1);
    check_output("reset resp_valid", 32'(resp_valid), 32'd0);
    check_output("reset resp_fetch", 32'(resp_fetch), 32'd0);
    check_output("reset resp_rdata", 32'(resp_rdata), 32'd0);
    check_output("reset mem_addr", 32'(mem_addr), 32'd0);
    check_output("reset strobes", 32'({mem_re, mem_we}), 32'd0);
    check_output("reset mem_wdata", 32'(mem_wdata), 32'd0);
    check_output("reset w2 req_ready", 32'(w2_req_ready), 32'd1);
    @(posedge clk); #1 rst = 1'b0;

    // Reserved opcode must leave the unit idle.
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = OP_RSVD;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_output($sformatf("rsvd strobes c%0d", k), 32'({mem_re, mem_we}), 32'd0);
      check_output($sformatf("rsvd ready c%0d", k), 32'(req_ready), 32'd1);
    end
    @(posedge clk); #1 req_valid = 1'b0;

    for (int i = 0; i < 10; i++) begin
      apply_stimulus(tbl[i].op, tbl[i].wide, tbl[i].desc, tbl[i].hip, tbl[i].addr, tbl[i].wdata, 1'b0);
      check_txn(i, tbl[i].op, int'(tbl[i].nb), tbl[i].a0, tbl[i].a1, tbl[i].wd0, tbl[i].wd1,
                tbl[i].rdata, tbl[i].fetch);
    end
    last_rdata = tbl[9].rdata;

    // WAIT_STATES=2 single read, memory stalls three cycles after the counter expires.
    @(posedge clk); #1;
    w2_req_valid = 1'b1; w2_req_op = OP_READ; w2_req_wide = 1'b0; w2_req_addr = 16'h4000;
    w2_mem_ready = 1'b0;
    @(posedge clk); #1;
    w2_req_valid = 1'b0;
    cnt = 0; stable = 1; lat = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (w2_mem_re) begin
        cnt++;
        if (w2_mem_addr !== 16'h4000) stable = 0;
      end
      if (w2_resp_valid) begin lat = k; exp_rd = w2_resp_rdata; break; end
      @(posedge clk); #1;
      w2_mem_ready = (k + 1 >= 6);
    end
    w2_mem_ready = 1'b1;
    check_output("ws2 read beat cycles", 32'(cnt), 32'd6);
    check_output("ws2 read addr stable", 32'(stable), 32'd1);
    check_output("ws2 read latency", 32'(lat), 32'd7);
    check_output("ws2 read rdata", 32'(exp_rd), 32'h00A5);

    // WAIT_STATES=2 wide write: each beat holds for three cycles, counter reloads for beat 2.
    @(posedge clk); #1;
    w2_req_valid = 1'b1; w2_req_op = OP_WRITE; w2_req_wide = 1'b1; w2_req_desc = 1'b0;
    w2_req_addr = 16'h40FF; w2_req_wdata = 16'hC3D2;
    @(posedge clk); #1;
    w2_req_valid = 1'b0;
    cnt = 0; stable = 1; lat = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (w2_mem_we) begin
        cnt++;
        if (cnt <= 3 && (w2_mem_addr !== 16'h40FF || w2_mem_wdata !== 8'hD2)) stable = 0;
        if (cnt > 3 && (w2_mem_addr !== 16'h4100 || w2_mem_wdata !== 8'hC3)) stable = 0;
      end
      if (w2_resp_valid) begin lat = k; break; end
    end
    check_output("ws2 write we cycles", 32'(cnt), 32'd6);
    check_output("ws2 write beats stable", 32'(stable), 32'd1);
    check_output("ws2 write latency", 32'(lat), 32'd7);

    // Random transfers with random stalls, checked against a byte-addressed memory model.
    for (int i = 0; i < 40; i++) begin
      op   = 2'($urandom_range(0, 2));
      wide = 1'($urandom); desc = 1'($urandom); hip = 1'($urandom);
      wdata = 16'($urandom);
      case ($urandom_range(0, 5))
        0:       addr = 16'hFFFF;
        1:       addr = 16'h0000;
        2:       addr = {8'($urandom), 8'hFF};
        3:       addr = {8'($urandom), 8'h00};
        default: addr = 16'($urandom);
      endcase
      eff   = hip ? (16'hFF00 | {8'h00, addr[7:0]}) : addr;
      nb    = (wide && op != OP_FETCH) ? 2 : 1;
      a1raw = desc ? (eff - 16'd1) : (eff + 16'd1);
      a1    = hip ? (16'hFF00 | {8'h00, a1raw[7:0]}) : a1raw;
      b0 = mem_arr[eff]; b1 = mem_arr[a1];
      wd0 = (nb == 2 && desc) ? wdata[15:8] : wdata[7:0];
      wd1 = desc ? wdata[7:0] : wdata[15:8];
      if (op == OP_WRITE) exp_rd = last_rdata;
      else if (nb == 1)   exp_rd = {8'h00, b0};
      else if (desc)      exp_rd = {b0, b1};
      else                exp_rd = {b1, b0};
      apply_stimulus(op, wide, desc, hip, addr, wdata, 1'b1);
      check_txn(100 + i, op, nb, eff, a1, wd0, wd1, exp_rd, op == OP_FETCH);
      last_rdata = exp_rd;
    end

    // Reset during the second beat of a wide write drops the strobe and the response.
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = OP_WRITE; req_wide = 1'b1; req_desc = 1'b0; req_hipage = 1'b0;
    req_addr = 16'h2000; req_wdata = 16'h1122; mem_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check_output("midrst beat0 we", 32'(mem_we), 32'd1);
    @(negedge clk);
    check_output("midrst beat1 addr", 32'(mem_addr), 32'h2001);
    rst = 1'b1;
    #1;
    check_output("midrst we dropped", 32'(mem_we), 32'd0);
    check_output("midrst ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1 rst = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    check_output("midrst no resp", 32'(seen), 32'd0);
    check_output("midrst ready after", 32'(req_ready), 32'd1);
    check_output("midrst rdata cleared", 32'(resp_rdata), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
